mem_responder: RTL

Memory-side responder for the core's instruction-fetch and load/store requests. It replaces the DPI-C memory path with a synthesizable, cycle-accurate slave: it accepts one request at a time over a valid/ready request channel and returns data or status over a valid/ready response channel after a fixed latency. It is backed by an internal 64-bit-wide word array and sits between the core (`fetch`/`memory` initiators) and the simulation top.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave with valid/ready request and
// response channels, fixed response latency and a 64-bit word array.
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to fault requests whose
// address is not aligned to their access size.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request (req_ready = 1)
// WAIT   | latency countdown after accept
// RESP   | response presented (rsp_valid = 1) until rsp_ready

module mem_responder #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT is entered one edge after accept and left on the edge the counter
  // reads zero, so LATENCY-2 gives LATENCY edges from accept to RESP.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [63:0]       mem [DEPTH];
  logic [63:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              range_err;
  logic              align_err;
  logic              access_err;
  logic              accept;

  // Offset is taken in full 64 bits so an address below the base can never
  // alias into the array; it is caught by the explicit compare instead.
  assign offset    = req_addr - ADDR_BASE;
  assign range_err = (req_addr < ADDR_BASE) || ((offset >> 3) >= 64'(DEPTH));
  assign idx       = offset[IDX_W+2:3];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  // Size-dependent alignment fault: low address bits must be zero.
  always_comb begin
    align_err = 1'b0;
    case (req_size)
      2'd1:    align_err = req_addr[0];
      2'd2:    align_err = |req_addr[1:0];
      2'd3:    align_err = |req_addr[2:0];
      default: align_err = 1'b0;
    endcase
  end
`else
  logic unused_size;
  assign unused_size = ^req_size;
  assign align_err   = 1'b0;
`endif

  assign access_err = range_err || align_err;
  assign req_ready  = (state == ST_IDLE) && !rst;
  assign rsp_valid  = (state == ST_RESP);
  assign accept     = req_valid && req_ready;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latency counter and response registers; response is captured at
  // accept and held untouched until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= CNT_LOAD;
        rsp_err   <= access_err;
        rsp_rdata <= (access_err || req_wen) ? 64'd0 : mem[idx];
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Byte-lane array write at accept; array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !access_err) begin
      for (int i = 0; i < 8; i++) begin
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule
